// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD frame sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_START,
    SEQ_WAIT,
    SEQ_RUN,
    SEQ_GAP
  } lcd_seq_state_e;

  // Smallest usable start timeout: one START clock plus at least one WAIT clock.
  localparam int LCD_SEQ_MIN_TIMEOUT = 2;

  // Clamp a requested start timeout to the usable minimum.
  function automatic int lcd_seq_timeout_eff(input int t);
    return (t < LCD_SEQ_MIN_TIMEOUT) ? LCD_SEQ_MIN_TIMEOUT : t;
  endfunction

endpackage

// File: rtl/lcd_underflow_monitor.sv
// Pixel underflow monitor: sticky flag plus saturating clock count.
// Only instantiated when LCD_SEQ_UNDERFLOW_MON_EN is defined.
module lcd_underflow_monitor
  import lcd_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             hit,
  output logic             flag,
  output logic [CNT_W-1:0] cnt
);

  // A hit in the same clock as clear wins: flag stays set and the count restarts at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag <= 1'b0;
      cnt  <= '0;
    end else begin
      if (hit)
        flag <= 1'b1;
      else if (clear)
        flag <= 1'b0;

      if (clear)
        cnt <= hit ? CNT_W'(1) : '0;
      else if (hit && (cnt != '1))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Frame-level controller for the LCD timing generator: start pulses, busy tracking,
// inter-frame gap, continuous / single-shot operation, start timeout detection.
// Optional build macro: LCD_SEQ_UNDERFLOW_MON_EN enables the pixel underflow monitor.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SEQ_IDLE  | no frame in progress, waiting for enable or a single request
// SEQ_START | tg_start_o high for exactly this clock
// SEQ_WAIT  | waiting for tg_busy_i to rise, start timeout running
// SEQ_RUN   | frame active, watching for tg_busy_i falling edge
// SEQ_GAP   | inter-frame idle clocks counting down
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int GAP_W         = 16,
  parameter int FRAME_CNT_W   = 16,
  parameter int START_TIMEOUT = 16,
  parameter int UFLOW_CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   single_i,
  input  logic                   clear_i,
  input  logic [GAP_W-1:0]       gap_cycles_i,
  output logic                   tg_start_o,
  input  logic                   tg_busy_i,
  input  logic                   tg_enable_i,
  input  logic                   pix_valid_i,
  output logic                   frame_done_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic                   idle_o,
  output logic                   timeout_o,
  output logic                   underflow_o,
  output logic [UFLOW_CNT_W-1:0] underflow_cnt_o
);

  localparam int TIMEOUT_EFF = lcd_seq_timeout_eff(START_TIMEOUT);
  localparam int TO_W        = (TIMEOUT_EFF > 2) ? $clog2(TIMEOUT_EFF) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_EFF - 1);

  lcd_seq_state_e state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  // Counts clocks since the start pulse: 0 in START, 1 on the first WAIT clock.
  logic [TO_W-1:0] to_cnt_q;
  logic pend_q;
  logic busy_q;
  logic frame_end;
  logic decide;
  logic to_hit;

  logic tg_start_q;
  logic frame_done_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic idle_q;
  logic timeout_q;

  // Next-state logic; the continue/stop decision is shared by RUN (gap 0) and GAP.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    frame_end = 1'b0;
    decide    = 1'b0;
    to_hit    = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (enable_i || pend_q || single_i)
          state_d = SEQ_START;
      end
      SEQ_START: begin
        state_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (tg_busy_i) begin
          state_d = SEQ_RUN;
        end else if (to_cnt_q == TO_LAST) begin
          to_hit  = 1'b1;
          state_d = SEQ_IDLE;
        end
      end
      SEQ_RUN: begin
        if (busy_q && !tg_busy_i) begin
          frame_end = 1'b1;
          if (gap_cycles_i == '0) begin
            decide = 1'b1;
          end else begin
            gap_d   = gap_cycles_i;
            state_d = SEQ_GAP;
          end
        end
      end
      SEQ_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == GAP_W'(1))
          decide = 1'b1;
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
    if (decide)
      state_d = (enable_i || pend_q) ? SEQ_START : SEQ_IDLE;
  end

  // State, counters, pending single request and busy history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SEQ_IDLE;
      gap_q    <= '0;
      to_cnt_q <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      to_cnt_q <= (state_d == SEQ_START) ? '0 : to_cnt_q + 1'b1;
      pend_q   <= (state_d == SEQ_START) ? 1'b0 : (pend_q | single_i);
      busy_q   <= tg_busy_i;
    end
  end

  // Registered outputs, all derived from the next state so they align with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tg_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      idle_q       <= 1'b1;
      timeout_q    <= 1'b0;
    end else begin
      tg_start_q   <= (state_d == SEQ_START);
      frame_done_q <= frame_end;
      if (frame_end)
        frame_cnt_q <= frame_cnt_q + 1'b1;
      idle_q <= (state_d == SEQ_IDLE);
      if (to_hit)
        timeout_q <= 1'b1;
      else if (clear_i)
        timeout_q <= 1'b0;
    end
  end

  assign tg_start_o   = tg_start_q;
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign idle_o       = idle_q;
  assign timeout_o    = timeout_q;

`ifdef LCD_SEQ_UNDERFLOW_MON_EN
  logic uflow_hit;
  assign uflow_hit = (state_q == SEQ_RUN) && tg_enable_i && !pix_valid_i;

  lcd_underflow_monitor #(
    .CNT_W(UFLOW_CNT_W)
  ) u_uflow (
    .clk  (clk_i),
    .rst  (rst_i),
    .clear(clear_i),
    .hit  (uflow_hit),
    .flag (underflow_o),
    .cnt  (underflow_cnt_o)
  );
`else
  logic unused_uflow_inputs;
  assign unused_uflow_inputs = tg_enable_i ^ pix_valid_i;
  assign underflow_o     = 1'b0;
  assign underflow_cnt_o = '0;
`endif

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Bench for lcd_frame_sequencer with a small timing-generator stub and an event-time model.
module tb_lcd_frame_sequencer;

  localparam int FCW  = 2;
  localparam int UCW  = 2;
  localparam int TOUT = 16;
  localparam int FLEN = 10;

  logic clk = 1'b0;
  logic rst, enable, single, clear;
  logic [15:0] gap;
  logic tg_start, tg_busy, tg_en, pix_valid;
  logic frame_done, idle, timeout, uf;
  logic [FCW-1:0] fcnt;
  logic [UCW-1:0] ufcnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lcd_frame_sequencer #(
    .GAP_W(16), .FRAME_CNT_W(FCW), .START_TIMEOUT(TOUT), .UFLOW_CNT_W(UCW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .single_i(single), .clear_i(clear),
    .gap_cycles_i(gap), .tg_start_o(tg_start), .tg_busy_i(tg_busy), .tg_enable_i(tg_en),
    .pix_valid_i(pix_valid), .frame_done_o(frame_done), .frame_cnt_o(fcnt), .idle_o(idle),
    .timeout_o(timeout), .underflow_o(uf), .underflow_cnt_o(ufcnt)
  );

  // timing generator stub
  int tg_left = 0;
  bit tg_mute = 0;
  int uf_req = 0;
  int uf_done = 0;

  // observations
  int cyc = 0;
  int n_start = 0;
  int last_start = -1;
  int to_seen = -1;
  int iv_q[$];
  int fc_q[$];

  // model: event times instead of states
  bit m_valid = 0, m_idle = 1, m_frame = 0, m_pend = 0, m_prev_busy = 0;
  int m_wait_from = -1;
  int m_decide = -1;
  logic e_start, e_done, e_idle, e_to, e_uf;
  int e_cnt, e_ufc;

  int exp4[5] = '{1, 2, 3, 0, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit was_idle, go, to_set, hit;
    was_idle = m_idle;
    e_start = 1'b0;
    e_done  = 1'b0;
    if (rst) begin
      m_idle = 1; m_frame = 0; m_pend = 0; m_wait_from = -1; m_decide = -1;
      e_cnt = 0; e_idle = 1; e_to = 0; e_uf = 0; e_ufc = 0;
      m_valid = 1;
    end else begin
      go = 0; to_set = 0;
      hit = m_frame && tg_en && !pix_valid;
      if (m_wait_from >= 0 && cyc > m_wait_from) begin
        if (tg_busy) begin
          m_frame = 1; m_wait_from = -1;
        end else if (cyc - m_wait_from == TOUT - 1) begin
          to_set = 1; m_wait_from = -1; m_idle = 1;
        end
      end else if (m_frame && m_prev_busy && !tg_busy) begin
        m_frame = 0;
        e_done = 1;
        e_cnt = (e_cnt + 1) % (1 << FCW);
        m_decide = cyc + int'(gap);
      end
      if (was_idle && (enable || m_pend || single)) go = 1;
      else if (m_decide == cyc) begin
        if (enable || m_pend) go = 1;
        else m_idle = 1;
      end
      if (m_decide == cyc) m_decide = -1;
      if (go) begin
        m_idle = 0; m_wait_from = cyc + 1; e_start = 1;
      end
      m_pend = go ? 1'b0 : (m_pend | single);
      e_idle = m_idle;
      e_to = to_set ? 1'b1 : (clear ? 1'b0 : e_to);
`ifdef LCD_SEQ_UNDERFLOW_MON_EN
      e_uf = hit ? 1'b1 : (clear ? 1'b0 : e_uf);
      if (clear) e_ufc = hit ? 1 : 0;
      else if (hit && e_ufc != (1 << UCW) - 1) e_ufc = e_ufc + 1;
`else
      e_uf = 1'b0;
      e_ufc = 0;
`endif
    end
    m_prev_busy = tg_busy;
  endtask

  // One clock: compare at negedge, advance model, then drive stub after the edge.
  task automatic step();
    logic st;
    @(negedge clk);
    cyc++;
    if (m_valid) begin
      chk("tg_start", tg_start, e_start);
      chk("frame_done", frame_done, e_done);
      chk("frame_cnt", fcnt, e_cnt);
      chk("idle", idle, e_idle);
      chk("timeout", timeout, e_to);
      chk("underflow", uf, e_uf);
      chk("underflow_cnt", ufcnt, e_ufc);
    end
    if (tg_start === 1'b1) begin
      n_start++;
      if (last_start >= 0) iv_q.push_back(cyc - last_start);
      last_start = cyc;
    end
    if (frame_done === 1'b1) fc_q.push_back(int'(fcnt));
    if (timeout === 1'b1 && to_seen < 0) to_seen = cyc;
    model_update();
    st = tg_start;
    @(posedge clk);
    #1;
    if (st === 1'b1 && !tg_mute) tg_left = FLEN;
    if (tg_left > 0) begin
      tg_busy = 1'b1;
      tg_en = (tg_left < FLEN) && (tg_left > 1);
      tg_left--;
    end else begin
      tg_busy = 1'b0;
      tg_en = 1'b0;
    end
    if (tg_en && uf_done < uf_req) begin
      pix_valid = 1'b0;
      uf_done++;
    end else begin
      pix_valid = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_single();
    single = 1'b1; step(); single = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget);
    for (int i = 0; i < budget && n_start < target; i++) step();
  endtask

  initial begin
    int n0;
    rst = 1; enable = 0; single = 0; clear = 0; gap = '0;
    tg_busy = 0; tg_en = 0; pix_valid = 1;
    run(3);
    rst = 0;
    chk("reset_idle", idle, 1);
    chk("reset_frame_cnt", fcnt, 0);
    chk("reset_tg_start", tg_start, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_underflow", uf, 0);
    run(2);

    // single-shot, gap 0
    pulse_single();
    run(20);
    chk("t1_starts", n_start, 1);
    chk("t1_frame_cnt", fcnt, 1);
    chk("t1_idle", idle, 1);
    chk("t1_done_pulses", fc_q.size(), 1);

    // continuous, gap 5; single while enabled must not add a frame
    gap = 16'd5; last_start = -1; iv_q.delete();
    n0 = n_start;
    enable = 1;
    wait_starts(n0 + 1, 30);
    run(3);
    pulse_single();
    wait_starts(n0 + 3, 100);
    run(4);
    enable = 0;
    run(40);
    chk("t2_starts", n_start - n0, 3);
    chk("t2_intervals", iv_q.size(), 2);
    for (int i = 0; i < iv_q.size(); i++) chk("t2_start_to_start", iv_q[i], FLEN + 7);
    chk("t2_frame_cnt_wrapped", fcnt, 0);
    chk("t2_idle", idle, 1);

    // start timeout
    tg_mute = 1; gap = '0;
    n0 = n_start; to_seen = -1;
    pulse_single();
    wait_starts(n0 + 1, 10);
    run(25);
    chk("t3_timeout_latency", to_seen - last_start, 16);
    chk("t3_timeout", timeout, 1);
    chk("t3_idle", idle, 1);
    tg_mute = 0;
    clear = 1; single = 1; step(); clear = 0; single = 0;
    step();
    chk("t3_cleared", timeout, 0);
    run(25);
    chk("t3_frame_after_clear", fcnt, 1);

    // underflow: 7 active clocks without pixels
    uf_req = uf_done + 7;
    pulse_single();
    run(25);
`ifdef LCD_SEQ_UNDERFLOW_MON_EN
    chk("t5_underflow", uf, 1);
    chk("t5_underflow_cnt_sat", ufcnt, 3);
    clear = 1; step(); clear = 0; step();
    chk("t5_underflow_cleared", uf, 0);
`else
    chk("t5_underflow_off", uf, 0);
    chk("t5_underflow_cnt_off", ufcnt, 0);
`endif

    // reset mid-RUN, then a normal frame
    n0 = n_start;
    pulse_single();
    wait_starts(n0 + 1, 10);
    run(4);
    rst = 1; step(); rst = 0;
    chk("t6_idle", idle, 1);
    chk("t6_frame_cnt", fcnt, 0);
    chk("t6_tg_start", tg_start, 0);
    chk("t6_frame_done", frame_done, 0);
    chk("t6_timeout", timeout, 0);
    run(12);
    n0 = n_start;
    pulse_single();
    run(20);
    chk("t6_restart_starts", n_start - n0, 1);
    chk("t6_restart_cnt", fcnt, 1);

    // frame counter wrap over 5 back-to-back frames
    rst = 1; step(); rst = 0;
    run(2);
    fc_q.delete();
    n0 = n_start;
    enable = 1; gap = '0;
    wait_starts(n0 + 5, 200);
    run(2);
    enable = 0;
    run(20);
    chk("t4_frames", fc_q.size(), 5);
    for (int i = 0; i < fc_q.size() && i < 5; i++) chk("t4_frame_cnt_seq", fc_q[i], exp4[i]);
    chk("t4_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
